// File: rtl/linear_network_unicast_seq.sv
// Daisy-chain unicast network: one producer, NUM_NODE consumers. Each word walks one stage per
// enabled clock and is delivered (and dropped from the chain) at the node matching its tag.
module linear_network_unicast_seq #(
    parameter int unsigned  DATA_WIDTH    = 32,
    parameter int unsigned  NUM_NODE      = 4,
    localparam int unsigned COMMAND_WIDTH = $clog2(NUM_NODE)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_en,
    input  logic                           i_valid,
    input  logic [DATA_WIDTH-1:0]          i_data_bus,
    input  logic [COMMAND_WIDTH-1:0]       i_cmd,
    output logic [NUM_NODE-1:0]            o_valid,
    output logic [NUM_NODE*DATA_WIDTH-1:0] o_data_bus
);

    logic [NUM_NODE-1:0]      s_valid;
    logic [DATA_WIDTH-1:0]    s_data [NUM_NODE];
    logic [COMMAND_WIDTH-1:0] s_dest [NUM_NODE];

    // A stage holds a word addressed to itself when valid and the tag matches its index
    logic [NUM_NODE-1:0] s_hit;

    always_comb begin
        s_hit = '0;
        for (int k = 0; k < NUM_NODE; k++) begin
            s_hit[k] = s_valid[k] && (s_dest[k] == COMMAND_WIDTH'(k));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid <= '0;
            for (int k = 0; k < NUM_NODE; k++) begin
                s_data[k] <= '0;
                s_dest[k] <= '0;
            end
        end else if (i_en) begin
            s_valid[0] <= i_valid;
            s_data[0]  <= i_data_bus;
            s_dest[0]  <= i_cmd;
            // Delivered words are consumed; only misses move on to the next stage
            for (int k = 0; k < NUM_NODE - 1; k++) begin
                s_valid[k+1] <= s_valid[k] & ~s_hit[k];
                s_data[k+1]  <= s_data[k];
                s_dest[k+1]  <= s_dest[k];
            end
        end
    end

    always_comb begin
        o_valid    = '0;
        o_data_bus = '0;
        for (int k = 0; k < NUM_NODE; k++) begin
            o_valid[k] = i_en & s_hit[k];
            if (o_valid[k]) begin
                o_data_bus[k*DATA_WIDTH +: DATA_WIDTH] = s_data[k];
            end
        end
    end

endmodule

// File: tb/tb_linear_network_unicast_seq.sv
// Scoreboard bench for linear_network_unicast_seq: stimulus pushes expected deliveries,
// a negedge monitor compares o_valid/o_data_bus every cycle against the due entries.
module tb_linear_network_unicast_seq;

    localparam int DW = 32;
    localparam int NN = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            i_en = 1'b0;
    logic            i_valid = 1'b0;
    logic [DW-1:0]   i_data_bus = '0;
    logic [1:0]      i_cmd = '0;
    logic [NN-1:0]   o_valid;
    logic [NN*DW-1:0] o_data_bus;

    linear_network_unicast_seq #(
        .DATA_WIDTH(DW),
        .NUM_NODE  (NN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_en      (i_en),
        .i_valid   (i_valid),
        .i_data_bus(i_data_bus),
        .i_cmd     (i_cmd),
        .o_valid   (o_valid),
        .o_data_bus(o_data_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [1:0]  node;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int unsigned en_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          seen_all = 0;

    // Counts enabled edges; a word is due when this reaches its sample index plus its tag
    always @(posedge clk) begin
        if (!rst && i_en) en_cnt <= en_cnt + 1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    logic [NN-1:0]    em;
    logic [NN*DW-1:0] ed;

    always @(negedge clk) begin
        em = '0;
        ed = '0;
        if (!rst && i_en) begin
            for (int j = sb.size() - 1; j >= 0; j--) begin
                if (sb[j].due == en_cnt) begin
                    em[sb[j].node] = 1'b1;
                    ed[sb[j].node*DW +: DW] = sb[j].data;
                    sb.delete(j);
                end
            end
        end
        for (int j = sb.size() - 1; j >= 0; j--) begin
            if (!rst && sb[j].due < en_cnt) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missed_delivery node %0d data %h: never seen, due %0d now %0d",
                         sb[j].node, sb[j].data, sb[j].due, en_cnt);
                sb.delete(j);
            end
        end
        if (o_valid == 4'b1111) seen_all = 1;
        check("o_valid", 128'(o_valid), 128'(em));
        check("o_data_bus", 128'(o_data_bus), 128'(ed));
    end

    task automatic send(input logic [31:0] data, input logic [1:0] cmd);
        exp_t e;
        @(posedge clk);
        #2;
        i_en       = 1'b1;
        i_valid    = 1'b1;
        i_data_bus = data;
        i_cmd      = cmd;
        e.due  = en_cnt + 1 + int'(cmd);
        e.node = cmd;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic idle(input int n, input logic en);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            i_en    = en;
            i_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        while (sb.size() != 0 && budget > 0) begin
            idle(1, 1'b1);
            budget--;
        end
        idle(2, 1'b1);
        check("drain_empty", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        // 1. async reset, outputs clear without any clock edge
        #1 rst = 1'b1;
        #1;
        check("reset_async_valid", 128'(o_valid), 128'(0));
        check("reset_async_data", 128'(o_data_bus), 128'(0));
        idle(3, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        idle(2, 1'b1);

        // 2. unicast to node 1
        send(32'hAAAAAAAA, 2'd1);
        drain();

        // 3. unicast to last node
        send(32'hBBBBBBBB, 2'd3);
        drain();

        // 4. back-to-back, all four land together
        send(32'd1, 2'd3);
        send(32'd2, 2'd2);
        send(32'd3, 2'd1);
        send(32'd4, 2'd0);
        drain();
        check("all_four_same_cycle", 128'(seen_all), 128'(1));

        // 5. stall mid-flight for three cycles
        send(32'hCCCC0002, 2'd2);
        idle(1, 1'b1);
        idle(3, 1'b0);
        drain();

        // 6. bubbles carry nothing regardless of payload/tag
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            i_en       = 1'b1;
            i_valid    = 1'b0;
            i_data_bus = 32'hBBBBBBBB;
            i_cmd      = 2'd0;
        end
        drain();

        // async reset while words are in flight drops them
        send(32'hDEAD0002, 2'd2);
        send(32'hDEAD0003, 2'd3);
        @(posedge clk);
        #2;
        i_valid = 1'b0;
        rst     = 1'b1;
        sb.delete();
        #1;
        check("midflight_reset_valid", 128'(o_valid), 128'(0));
        check("midflight_reset_data", 128'(o_data_bus), 128'(0));
        idle(2, 1'b1);
        @(posedge clk);
        #2 rst = 1'b0;
        idle(6, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
